// File: rtl/cpu_alu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_alu_pkg
// Shared definitions for the nibble-serial ALU blocks.
//   state_t  : three-state sequencer encoding (IDLE / BUSY / DONE)
//   NIBBLE_W : width of the carry-lookahead slice processed per cycle
// ---------------------------------------------------------------------------
package cpu_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage : cpu_alu_pkg

// File: rtl/adder_4bits.sv
// ---------------------------------------------------------------------------
// adder_4bits
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b : 4-bit operands
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
// ---------------------------------------------------------------------------
module adder_4bits
    import cpu_alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] gen;
    logic [NIBBLE_W-1:0] prop;
    logic [NIBBLE_W:0]   carry;

    assign carry[0] = cin;

    // Each carry is expanded from generate/propagate terms so the whole
    // chain is two logic levels deep rather than a ripple.
    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign gen[gi]  = a[gi] & b[gi];
            assign prop[gi] = a[gi] ^ b[gi];
            assign sum[gi]  = prop[gi] ^ carry[gi];
        end
    endgenerate

    assign carry[1] = gen[0] | (prop[0] & carry[0]);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & carry[0]);
    assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & carry[0]);

    assign cout = carry[NIBBLE_W];

endmodule : adder_4bits

// File: rtl/serial_add32.sv
// ---------------------------------------------------------------------------
// serial_add32
// Nibble-serial adder/subtractor. One operand pair is captured from IDLE,
// processed four bits per cycle (LSB first) through a single adder_4bits
// slice, and the result is held in DONE until the consumer takes it.
//
// Parameters
//   WIDTH     : operand width, multiple of 4 in 8..64 (default 32)
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : request present          in_ready  : accepting (IDLE only)
//   a, b      : operands                 sub       : 1 = a-b, 0 = a+b
//   out_valid : result held (DONE)       out_ready : consumer accepts result
//   sum       : result modulo 2^WIDTH    cout      : carry out (sub: 1 = no borrow)
// Optional (macro SERIAL_ADD_FLAGS_EN defined)
//   ovf       : signed overflow          zero      : sum == 0
// ---------------------------------------------------------------------------
module serial_add32
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NIB_CNT = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIB_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB_CNT - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    // Operand registers shift right each BUSY cycle, so the slice always
    // sees the current nibble in bits [3:0].
    adder_4bits u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef SERIAL_ADD_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
    logic msb_cin;

    // Carry into the top bit recovered from sum = a ^ b ^ cin on bit 3 of
    // the final nibble.
    assign msb_cin = slice_sum[NIBBLE_W-1] ^ a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction as a + ~b + 1: the +1 enters as carry-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NIB_CNT; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*NIBBLE_W +: NIBBLE_W] = slice_sum;
                    end
                end
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cout_d  = slice_cout;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_ADD_FLAGS_EN
                    ovf_d   = msb_cin ^ slice_cout;
                    zero_d  = (sum_d == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_FLAGS_EN
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = zero_q;
`endif

endmodule : serial_add32

// File: tb/tb_serial_add32.sv
// ---------------------------------------------------------------------------
// tb_serial_add32
// Directed-vector bench for serial_add32 (WIDTH = 32). Flag outputs are
// checked when SERIAL_ADD_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_add32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef SERIAL_ADD_FLAGS_EN
    logic        ovf;
    logic        zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, then wait for the result.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                            input string tag);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
        a = av; b = bv; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = ~s;
    endtask

    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'd8);
    endtask

    task automatic finish_op(input logic [31:0] es, input logic ec, input string tag);
        chk({tag, " sum"},  64'(sum),  64'(es));
        chk({tag, " cout"}, 64'(cout), 64'(ec));
        out_ready = 1'b1;
        #1;
        chk({tag, " in_ready low during handshake"}, 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid cleared"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
        chk({tag, " sum kept"}, 64'(sum), 64'(es));
        $display("op %s: sum=0x%08h cout=%0b", tag, sum, cout);
    endtask

    initial begin
        bit saw_valid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset sum",       64'(sum),       64'd0);
        chk("reset cout",      64'(cout),      64'd0);
`ifdef SERIAL_ADD_FLAGS_EN
        chk("reset ovf",  64'(ovf),  64'd0);
        chk("reset zero", 64'(zero), 64'd0);
`endif

        // 5 + 3
        start_op(32'h0000_0005, 32'h0000_0003, 1'b0, "add5_3");
        chk("add5_3 in_ready busy", 64'(in_ready), 64'd0);
        wait_result("add5_3");
        finish_op(32'h0000_0008, 1'b0, "add5_3");

        // Wrap to zero with carry out
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
        wait_result("wrap");
`ifdef SERIAL_ADD_FLAGS_EN
        chk("wrap zero", 64'(zero), 64'd1);
        chk("wrap ovf",  64'(ovf),  64'd0);
`endif
        finish_op(32'h0000_0000, 1'b1, "wrap");

        // 0x7FFFFFFF - (-1): signed overflow, borrow
        start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, "subovf");
        wait_result("subovf");
`ifdef SERIAL_ADD_FLAGS_EN
        chk("subovf ovf",  64'(ovf),  64'd1);
        chk("subovf zero", 64'(zero), 64'd0);
`endif
        finish_op(32'h8000_0000, 1'b0, "subovf");

        // Simple subtractions, no borrow and borrow
        start_op(32'h0000_0005, 32'h0000_0003, 1'b1, "sub5_3");
        wait_result("sub5_3");
        finish_op(32'h0000_0002, 1'b1, "sub5_3");
        start_op(32'h0000_0003, 32'h0000_0005, 1'b1, "sub3_5");
        wait_result("sub3_5");
        finish_op(32'hFFFF_FFFE, 1'b0, "sub3_5");

        // Consumer stall: out_ready low for 5 cycles in DONE
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, "stall");
        wait_result("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall out_valid c%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall sum c%0d", i),       64'(sum),       64'h2345_6789);
            chk($sformatf("stall in_ready c%0d", i),  64'(in_ready),  64'd0);
        end
        finish_op(32'h2345_6789, 1'b0, "stall");

        // Asynchronous reset in the middle of BUSY
        start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, "rstmid");
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("rstmid in_ready",  64'(in_ready),  64'd1);
        chk("rstmid out_valid", 64'(out_valid), 64'd0);
        chk("rstmid sum",       64'(sum),       64'd0);
        chk("rstmid cout",      64'(cout),      64'd0);
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("rstmid no out_valid", 64'(saw_valid), 64'd0);
        start_op(32'h0000_0002, 32'h0000_0002, 1'b0, "after_rst");
        wait_result("after_rst");
        finish_op(32'h0000_0004, 1'b0, "after_rst");

        // in_valid held high with changing operands; back-to-back requests
        a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            chk($sformatf("hold in_ready busy c%0d", i), 64'(in_ready), 64'd0);
            tick();
        end
        chk("hold out_valid", 64'(out_valid), 64'd1);
        chk("hold sum",       64'(sum),       64'h0000_0030);
        a = 32'h0000_0007; b = 32'h0000_0009; sub = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready at handshake", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("b2b idle after handshake", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        chk("b2b second accepted", 64'(in_ready), 64'd0);
        wait_result("b2b");
        finish_op(32'h0000_0010, 1'b0, "b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_add32

// File: doc/serial_add32.md
SERIAL_ADD32 -- requirements
Module: serial_add32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-006 SHALL have port a, input, WIDTH bits: first operand.
REQ-007 SHALL have port b, input, WIDTH bits: second operand.
REQ-008 SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b.
REQ-009 SHALL have port out_valid, output, 1 bit: result held and valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: result.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB nibble (for sub, 1 means no borrow).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL set in_ready=1 only in IDLE.
REQ-015 SHALL, on in_valid & in_ready, capture a, b (inverted when sub=1) and carry = sub, clear the nibble counter, and enter BUSY.
REQ-016 SHALL, in BUSY, process one nibble per cycle, LSB first, through one 4-bit slice; the slice result is written to sum[4k+3:4k] and the slice carry-out is registered as the next carry-in.
REQ-017 SHALL leave BUSY after exactly WIDTH/4 cycles (8 for the default); DONE is entered on the edge that writes the last nibble.
REQ-018 SHALL hold out_valid=1 in DONE, with sum and cout stable until the handshake.
REQ-019 SHALL return to IDLE on out_valid & out_ready; sum and cout keep their last values.
REQ-020 SHALL set the latency from the accept edge to out_valid to WIDTH/4 cycles.
REQ-021 SHALL ignore in_valid while BUSY or DONE, and ignore operand changes after capture.
REQ-022 SHALL ignore out_ready outside DONE.
REQ-023 SHALL produce results modulo 2^WIDTH, with wrap-around and no saturation.
REQ-024 SHALL NOT accept a new request in the same cycle that a DONE handshake completes; in_ready rises the following cycle.

Reset
REQ-025 SHALL, on rst, immediately enter IDLE and set in_ready=1, out_valid=0, sum=0, cout=0, carry=0 and counter=0, independent of clk.
REQ-026 SHALL, on rst asserted mid-BUSY or in DONE, discard the in-flight operation and produce no out_valid after release.

Configuration
REQ-027 SHALL, with SERIAL_ADD_FLAGS_EN defined, add outputs ovf (1 bit, signed overflow: carry into the MSB XOR cout) and zero (1 bit, sum==0); both are registered, valid with out_valid, and reset to 0.
REQ-028 SHALL, with SERIAL_ADD_FLAGS_EN undefined, omit the ovf and zero ports and their logic entirely.

Structure
REQ-029 SHALL take the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the nibble width constant (4) from shared package cpu_alu_pkg.
REQ-030 SHALL instantiate the existing 4-bit carry-lookahead slice adder_4bits as its only sub-module, fed by the shifted operand nibbles and the registered carry.

Verification
REQ-031 SHALL verify: a=0x0000_0005, b=0x0000_0003, sub=0 -> out_valid 8 cycles after accept, sum=0x0000_0008, cout=0.
REQ-032 SHALL verify: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1; with flags enabled, zero=1 and ovf=0.
REQ-033 SHALL verify: a=0x7FFF_FFFF, b=0xFFFF_FFFF, sub=1 -> sum=0x8000_0000, cout=0; with flags enabled, ovf=1.
REQ-034 SHALL verify: out_ready held low for 5 cycles in DONE -> out_valid and sum stable throughout; in_ready=0 until the cycle after the handshake.
REQ-035 SHALL verify: rst pulsed at BUSY cycle 4 -> outputs return to reset values asynchronously and no out_valid appears; a following request (a=2, b=2) completes with sum=4.
REQ-036 SHALL verify: in_valid held high with changing operands during BUSY -> only the first captured operands affect the result, and back-to-back requests are each accepted only from IDLE.
